// File: rtl/pc_gen_pkg.sv
// pc_gen shared types and defaults
// state encoding and reset/trap vectors
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_HALT = 2'd2
  } pcg_state_e;

  localparam int          PCG_ADDR_W     = 30;
  localparam logic [29:0] PCG_START_ADDR = 30'h0000C00;
  localparam logic [29:0] PCG_EXC_VEC    = 30'h0000C20;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-pc priority mux
// exc > branch > stall > jump > pending > pc+1
module pc_next_sel #(
  parameter int                ADDR_W  = 30,
  parameter logic [ADDR_W-1:0] EXC_VEC = '0
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_write,
  input  logic              exc_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              pend_vld,
  input  logic [ADDR_W-1:0] pend_tgt,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redir,
  output logic              pend_vld_n,
  output logic [ADDR_W-1:0] pend_tgt_n
);

  localparam logic [ADDR_W-1:0] ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  // priority selection of the next fetch address
  always_comb begin
    next_pc    = pc;
    redir      = 1'b0;
    pend_vld_n = pend_vld;
    pend_tgt_n = pend_tgt;
    if (exc_req) begin
      next_pc    = EXC_VEC;
      redir      = 1'b1;
      pend_vld_n = 1'b0;
    end else if (br_taken) begin
      next_pc    = br_target;
      redir      = 1'b1;
      pend_vld_n = 1'b0;
    end else if (!pc_write) begin
      if (jmp_req) begin
        pend_vld_n = 1'b1;
        pend_tgt_n = jmp_target;
      end
    end else if (jmp_req) begin
      next_pc = jmp_target;
      redir   = 1'b1;
    end else if (pend_vld) begin
      next_pc    = pend_tgt;
      redir      = 1'b1;
      pend_vld_n = 1'b0;
    end else begin
      next_pc = pc + ONE;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator
// BOOT/RUN/HALT fsm, pc register, pending jump
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = PCG_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = PCG_START_ADDR,
  parameter logic [ADDR_W-1:0] EXC_VEC    = PCG_EXC_VEC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              exc_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W+1:0] pc_byte,
  output logic              pc_valid,
  output logic              redirected,
  output logic              halted
);

  pcg_state_e        state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic              redir_n;
  logic              pend_vld, pend_vld_n;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_n;

  logic [ADDR_W-1:0] sel_pc;
  logic              sel_redir;
  logic              sel_pv;
  logic [ADDR_W-1:0] sel_pt;

  pc_next_sel #(
    .ADDR_W  (ADDR_W),
    .EXC_VEC (EXC_VEC)
  ) u_sel (
    .pc         (pc),
    .pc_write   (pc_write),
    .exc_req    (exc_req),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_req    (jmp_req),
    .jmp_target (jmp_target),
    .pend_vld   (pend_vld),
    .pend_tgt   (pend_tgt),
    .next_pc    (sel_pc),
    .redir      (sel_redir),
    .pend_vld_n (sel_pv),
    .pend_tgt_n (sel_pt)
  );

  assign pc_byte = {pc, 2'b00};

  // next state, next pc and pending latch
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    redir_n    = 1'b0;
    pend_vld_n = pend_vld;
    pend_tgt_n = pend_tgt;
    unique case (state)
      PCG_BOOT: state_n = PCG_RUN;
      PCG_RUN: begin
        if (halt_req && !exc_req && !br_taken) begin
          state_n = PCG_HALT;
        end else begin
          pc_n       = sel_pc;
          redir_n    = sel_redir;
          pend_vld_n = sel_pv;
          pend_tgt_n = sel_pt;
        end
      end
      PCG_HALT: begin
        if (exc_req) begin
          state_n    = PCG_RUN;
          pc_n       = EXC_VEC;
          redir_n    = 1'b1;
          pend_vld_n = 1'b0;
        end else if (resume) begin
          state_n = PCG_RUN;
        end
      end
      default: state_n = PCG_BOOT;
    endcase
  end

  // state, pc and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PCG_BOOT;
      pc         <= START_ADDR;
      pc_valid   <= 1'b0;
      redirected <= 1'b0;
      halted     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_tgt   <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pc_valid   <= (state_n == PCG_RUN);
      redirected <= redir_n;
      halted     <= (state_n == PCG_HALT);
      pend_vld   <= pend_vld_n;
      pend_tgt   <= pend_tgt_n;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test of pc_gen
// reference model plus literal spot checks
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        exc_req;
  logic        br_taken;
  logic [29:0] br_target;
  logic        jmp_req;
  logic [29:0] jmp_target;
  logic        halt_req;
  logic        resume;
  logic [29:0] pc;
  logic [31:0] pc_byte;
  logic        pc_valid;
  logic        redirected;
  logic        halted;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  pc_gen dut (
    .clk        (clk),
    .reset      (reset),
    .pc_write   (pc_write),
    .exc_req    (exc_req),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_req    (jmp_req),
    .jmp_target (jmp_target),
    .halt_req   (halt_req),
    .resume     (resume),
    .pc         (pc),
    .pc_byte    (pc_byte),
    .pc_valid   (pc_valid),
    .redirected (redirected),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // model: mode 0 boot, 1 run, 2 halt
  int          m_mode;
  logic [29:0] m_pc;
  bit          m_red;
  bit          m_pend;
  logic [29:0] m_ptgt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0;
      m_pc   = 30'hC00;
      m_red  = 0;
      m_pend = 0;
      m_ptgt = '0;
    end else begin
      bit r;
      r = 0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (exc_req) begin
          m_pc = 30'hC20; r = 1; m_pend = 0;
        end else if (br_taken) begin
          m_pc = br_target; r = 1; m_pend = 0;
        end else if (halt_req) begin
          m_mode = 2;
        end else if (!pc_write) begin
          if (jmp_req) begin
            m_pend = 1; m_ptgt = jmp_target;
          end
        end else if (jmp_req) begin
          m_pc = jmp_target; r = 1;
        end else if (m_pend) begin
          m_pc = m_ptgt; r = 1; m_pend = 0;
        end else begin
          m_pc = m_pc + 30'd1;
        end
      end else begin
        if (exc_req) begin
          m_mode = 1; m_pc = 30'hC20; r = 1; m_pend = 0;
        end else if (resume) begin
          m_mode = 1;
        end
      end
      m_red = r;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      n_total++;
      if (pc === m_pc && pc_byte === {m_pc, 2'b00} &&
          pc_valid === (m_mode == 1) &&
          redirected === m_red &&
          halted === (m_mode == 2)) begin
        n_pass++;
      end else begin
        $display("FAIL model t=%0t pc=%h/%h pcb=%h v=%b/%b r=%b/%b h=%b/%b",
                 $time, pc, m_pc, pc_byte, pc_valid, m_mode == 1,
                 redirected, m_red, halted, m_mode == 2);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    pc_write = 1'b1; exc_req = 1'b0; br_taken = 1'b0;
    jmp_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    br_target = '0; jmp_target = '0;
    idle();
    step(); step();
    chk("rst_pc", 32'(pc), 32'hC00);
    chk("rst_valid", 32'(pc_valid), 32'h0);
    chk("rst_red", 32'(redirected), 32'h0);
    // T1
    reset = 1'b1;
    chk_on = 1'b1;
    step();
    chk("t1_pc0", 32'(pc), 32'hC00);
    chk("t1_v0", 32'(pc_valid), 32'h1);
    step();
    chk("t1_pc1", 32'(pc), 32'hC01);
    step();
    chk("t1_pc2", 32'(pc), 32'hC02);
    // T2
    step(); step(); step();
    chk("t2_at", 32'(pc), 32'hC05);
    pc_write = 1'b0;
    step(); step(); step();
    chk("t2_hold", 32'(pc), 32'hC05);
    pc_write = 1'b1;
    step();
    chk("t2_rel", 32'(pc), 32'hC06);
    // T3
    pc_write = 1'b0; jmp_req = 1'b1; jmp_target = 30'hD00;
    step();
    chk("t3_hold", 32'(pc), 32'hC06);
    jmp_req = 1'b0;
    step();
    chk("t3_hold2", 32'(pc), 32'hC06);
    pc_write = 1'b1;
    step();
    chk("t3_pc", 32'(pc), 32'hD00);
    chk("t3_red", 32'(redirected), 32'h1);
    step();
    chk("t3_seq", 32'(pc), 32'hD01);
    chk("t3_red0", 32'(redirected), 32'h0);
    // T4: pending set, then all redirects at once
    pc_write = 1'b0; jmp_req = 1'b1; jmp_target = 30'hD80;
    step();
    exc_req = 1'b1; br_taken = 1'b1; br_target = 30'hE00;
    step();
    chk("t4_exc", 32'(pc), 32'hC20);
    chk("t4_red", 32'(redirected), 32'h1);
    idle();
    step();
    chk("t4_noplay", 32'(pc), 32'hC21);
    // T5
    br_taken = 1'b1; br_target = 30'h3FFFFFFF;
    step();
    chk("t5_max", 32'(pc), 32'h3FFFFFFF);
    chk("t5_byte", pc_byte, 32'hFFFFFFFC);
    br_taken = 1'b0;
    step();
    chk("t5_wrap", 32'(pc), 32'h0);
    chk("t5_red0", 32'(redirected), 32'h0);
    // branch beats halt
    br_taken = 1'b1; br_target = 30'hB00; halt_req = 1'b1;
    step();
    chk("brh_pc", 32'(pc), 32'hB00);
    chk("brh_run", 32'(halted), 32'h0);
    // T6
    idle();
    jmp_req = 1'b1; jmp_target = 30'hC10;
    step();
    jmp_req = 1'b0; halt_req = 1'b1;
    step();
    chk("t6_h", 32'(halted), 32'h1);
    chk("t6_v", 32'(pc_valid), 32'h0);
    chk("t6_pc", 32'(pc), 32'hC10);
    halt_req = 1'b0;
    step();
    resume = 1'b1;
    step();
    chk("t6_res", 32'(pc), 32'hC10);
    chk("t6_resv", 32'(pc_valid), 32'h1);
    resume = 1'b0;
    step();
    chk("t6_seq", 32'(pc), 32'hC11);
    // exc and resume together in HALT
    halt_req = 1'b1;
    step();
    halt_req = 1'b0; exc_req = 1'b1; resume = 1'b1;
    step();
    chk("hx_pc", 32'(pc), 32'hC20);
    chk("hx_red", 32'(redirected), 32'h1);
    idle();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step();
    // async reset mid-HALT
    #2 reset = 1'b0;
    #1;
    chk("ar_pc", 32'(pc), 32'hC00);
    chk("ar_h", 32'(halted), 32'h0);
    chk("ar_v", 32'(pc_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(); step(); step();
    chk("ar_run", 32'(pc), 32'hC02);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
